// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register IDs and
// the register-dump FSM state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SCAN = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/wb_dst_sel.sv
// Write-back destination selection: derives dst_e/dst_m from the retiring
// instruction's icode, register specifiers and condition flag.
module wb_dst_sel
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    input  logic       cnd,
    output logic [3:0] dst_e,
    output logic [3:0] dst_m
);

    always_comb begin
        dst_e = R_NONE;
        unique case (icode)
            I_RRMOVQ:                      dst_e = cnd ? rB : R_NONE;
            I_IRMOVQ, I_OPQ:               dst_e = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ: dst_e = R_RSP;
            default:                       dst_e = R_NONE;
        endcase
    end

    always_comb begin
        dst_m = R_NONE;
        unique case (icode)
            I_MRMOVQ, I_POPQ: dst_m = rA;
            default:          dst_m = R_NONE;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 SEQ write-back stage, register file with two read ports and a
// sequential register-dump engine. Define WB_FWD_EN for same-cycle read forwarding.
module writeback_regfile
    import y86_pkg::*;
#(
    parameter int NREG = 15,
    parameter int W    = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wb_valid,
    input  logic [3:0]   icode,
    input  logic [3:0]   rA,
    input  logic [3:0]   rB,
    input  logic         cnd,
    input  logic [W-1:0] valE,
    input  logic [W-1:0] valM,
    input  logic [3:0]   rd_a_idx,
    input  logic [3:0]   rd_b_idx,
    output logic [W-1:0] rd_a_data,
    output logic [W-1:0] rd_b_data,
    input  logic         dump_req,
    output logic         dump_busy,
    output logic         dump_valid,
    output logic [3:0]   dump_idx,
    output logic [W-1:0] dump_data
);

    localparam logic [3:0] NREG_L   = 4'(NREG);
    localparam logic [3:0] LAST_IDX = 4'(NREG - 1);

    logic [W-1:0] regs [NREG];
    logic [3:0]   dst_e;
    logic [3:0]   dst_m;
    dump_state_t  state;

    wb_dst_sel u_dst_sel (
        .icode (icode),
        .rA    (rA),
        .rB    (rB),
        .cnd   (cnd),
        .dst_e (dst_e),
        .dst_m (dst_m)
    );

    // The valM write comes last so it wins when dst_e == dst_m (popq %rsp).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_valid) begin
            if (dst_e < NREG_L) regs[dst_e] <= valE;
            if (dst_m < NREG_L) regs[dst_m] <= valM;
        end
    end

    function automatic logic [W-1:0] read_port(input logic [3:0] idx);
        logic [W-1:0] r;
        r = '0;
        if (idx < NREG_L) r = regs[idx];
`ifdef WB_FWD_EN
        if (wb_valid && dst_e != R_NONE && idx == dst_e) r = valE;
        if (wb_valid && dst_m != R_NONE && idx == dst_m) r = valM;
`endif
        return r;
    endfunction

    always_comb begin
        rd_a_data = read_port(rd_a_idx);
        rd_b_data = read_port(rd_b_idx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= DUMP_IDLE;
            dump_busy  <= 1'b0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
        end else begin
            unique case (state)
                DUMP_IDLE: begin
                    if (dump_req) begin
                        state      <= DUMP_SCAN;
                        dump_busy  <= 1'b1;
                        dump_valid <= 1'b1;
                        dump_idx   <= '0;
                    end
                end
                DUMP_SCAN: begin
                    if (dump_idx == LAST_IDX) begin
                        state      <= DUMP_DONE;
                        dump_valid <= 1'b0;
                        dump_idx   <= '0;
                    end else begin
                        dump_idx <= dump_idx + 4'd1;
                    end
                end
                DUMP_DONE: begin
                    state     <= DUMP_IDLE;
                    dump_busy <= 1'b0;
                end
                default: begin
                    state      <= DUMP_IDLE;
                    dump_busy  <= 1'b0;
                    dump_valid <= 1'b0;
                    dump_idx   <= '0;
                end
            endcase
        end
    end

    // Beat data reflects the array as updated by the previous edge.
    assign dump_data = dump_valid ? regs[dump_idx] : '0;

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized bench for writeback_regfile against a behavioural register-file model.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [3:0]  icode, rA, rB;
    logic        cnd;
    logic [63:0] valE, valM;
    logic [3:0]  rd_a_idx, rd_b_idx;
    logic [63:0] rd_a_data, rd_b_data;
    logic        dump_req;
    logic        dump_busy, dump_valid;
    logic [3:0]  dump_idx;
    logic [63:0] dump_data;

    int nvec = 0;
    int nerr = 0;
    logic [63:0] mem [16];

    writeback_regfile #(.NREG(15), .W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .icode      (icode),
        .rA         (rA),
        .rB         (rB),
        .cnd        (cnd),
        .valE       (valE),
        .valM       (valM),
        .rd_a_idx   (rd_a_idx),
        .rd_b_idx   (rd_b_idx),
        .rd_a_data  (rd_a_data),
        .rd_b_data  (rd_b_data),
        .dump_req   (dump_req),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ref_dst_e(input logic [3:0] ic, input logic [3:0] b, input logic c);
        if (ic == 4'h2) return c ? int'(b) : 15;
        if (ic == 4'h3 || ic == 4'h6) return int'(b);
        if (ic >= 4'h8 && ic <= 4'hB) return 4;
        return 15;
    endfunction

    function automatic int ref_dst_m(input logic [3:0] ic, input logic [3:0] a);
        if (ic == 4'h5 || ic == 4'hB) return int'(a);
        return 15;
    endfunction

    function automatic logic [63:0] ref_read(input logic [3:0] idx);
        int de, dm;
        de = ref_dst_e(icode, rB, cnd);
        dm = ref_dst_m(icode, rA);
        if (idx == 4'hF) return 64'd0;
`ifdef WB_FWD_EN
        if (wb_valid && dm != 15 && int'(idx) == dm) return valM;
        if (wb_valid && de != 15 && int'(idx) == de) return valE;
`endif
        return mem[idx];
    endfunction

    task automatic step(input logic wbv, input logic [3:0] ic, input logic [3:0] ra,
                        input logic [3:0] rb, input logic c, input logic [63:0] ve,
                        input logic [63:0] vm, input logic [3:0] ia, input logic [3:0] ib);
        int de, dm;
        @(negedge clk);
        wb_valid = wbv; icode = ic; rA = ra; rB = rb; cnd = c;
        valE = ve; valM = vm; rd_a_idx = ia; rd_b_idx = ib;
        #1;
        chk("rd_a", rd_a_data, ref_read(ia));
        chk("rd_b", rd_b_data, ref_read(ib));
        de = ref_dst_e(ic, rb, c);
        dm = ref_dst_m(ic, ra);
        @(posedge clk);
        if (wbv) begin
            if (de != 15) mem[de] = ve;
            if (dm != 15) mem[dm] = vm;
        end
        #1 wb_valid = 1'b0;
    endtask

    task automatic read_now(input string tag, input logic [3:0] idx, input logic [63:0] exp);
        @(negedge clk);
        wb_valid = 1'b0;
        rd_a_idx = idx;
        #1 chk(tag, rd_a_data, exp);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 64'd0;
        reset = 1'b1; wb_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
        valE = '0; valM = '0; rd_a_idx = 4'hF; rd_b_idx = 4'hF; dump_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        for (int i = 0; i < 15; i++) read_now("rst_reg", 4'(i), 64'd0);
        read_now("rst_rnone", 4'hF, 64'd0);
        chk("rst_busy", {63'd0, dump_busy}, 64'd0);
        chk("rst_valid", {63'd0, dump_valid}, 64'd0);
        chk("rst_idx", {60'd0, dump_idx}, 64'd0);
        chk("rst_data", dump_data, 64'd0);

        // Directed write-back cases
        step(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'hAAAA, 64'h0, 4'hF, 4'hF);
        read_now("irmovq", 4'h2, 64'hAAAA);
        step(1'b0, 4'h3, 4'hF, 4'h2, 1'b0, 64'hBBBB, 64'h0, 4'h2, 4'hF);
        read_now("wb_off", 4'h2, 64'hAAAA);
        step(1'b1, 4'h2, 4'h1, 4'h3, 1'b0, 64'h5, 64'h0, 4'h3, 4'hF);
        read_now("cmov_nc", 4'h3, 64'h0);
        step(1'b1, 4'h2, 4'h1, 4'h3, 1'b1, 64'h5, 64'h0, 4'h3, 4'hF);
        read_now("cmov_c", 4'h3, 64'h5);
        step(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'h200, 4'h4, 4'hF);
        read_now("popq_rsp", 4'h4, 64'h200);

        @(negedge clk);
        wb_valid = 1'b1; icode = 4'h6; rA = 4'h1; rB = 4'h4; cnd = 1'b0;
        valE = 64'h55; valM = 64'h0; rd_b_idx = 4'h4;
        #1;
`ifdef WB_FWD_EN
        chk("opq_same", rd_b_data, 64'h55);
`else
        chk("opq_same", rd_b_data, 64'h200);
`endif
        @(posedge clk);
        mem[4] = 64'h55;
        #1 wb_valid = 1'b0;
        read_now("opq_next", 4'h4, 64'h55);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom), {$urandom, $urandom},
                 {$urandom, $urandom}, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Dump with a stray second request
        for (int i = 0; i < 15; i++)
            step(1'b1, 4'h3, 4'hF, 4'(i), 1'b0, 64'(i * 16), 64'h0, 4'hF, 4'hF);
        @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            chk("dump_valid", {63'd0, dump_valid}, 64'd1);
            chk("dump_busy", {63'd0, dump_busy}, 64'd1);
            chk("dump_idx", {60'd0, dump_idx}, 64'(k));
            chk("dump_data", dump_data, 64'(k * 16));
            dump_req = (k == 3);
        end
        @(negedge clk);
        chk("done_valid", {63'd0, dump_valid}, 64'd0);
        chk("done_busy", {63'd0, dump_busy}, 64'd1);
        @(negedge clk);
        chk("idle_busy", {63'd0, dump_busy}, 64'd0);

        // Reset in the middle of a dump
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            chk("dump2_idx", {60'd0, dump_idx}, 64'(k));
            chk("dump2_data", dump_data, 64'(k * 16));
        end
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_busy", {63'd0, dump_busy}, 64'd0);
        chk("mid_rst_valid", {63'd0, dump_valid}, 64'd0);
        chk("mid_rst_idx", {60'd0, dump_idx}, 64'd0);
        chk("mid_rst_data", dump_data, 64'd0);
        for (int i = 0; i < 16; i++) mem[i] = 64'd0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {63'd0, dump_valid}, 64'd0);
        for (int i = 0; i < 15; i++) read_now("post_rst_reg", 4'(i), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
